// File: rtl/lau_pkg.sv
// Shared types and helpers for the arithmetic unit library.
package lau_pkg;

  typedef enum logic [1:0] {
    SLOW   = 2'd0,
    MEDIUM = 2'd1,
    FAST   = 2'd2
  } speed_e;

  // Width of an index into n items; never zero, so a single item still gets a 1-bit id.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/inc_share_arbiter_if.sv
// Request/response bundle of the shared incrementer.
// Both channels are valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// ReqReady may depend on ReqValid and RspReady, but ReqValid never depends on ReqReady.
interface inc_share_arbiter_if
  import lau_pkg::*;
#(
  parameter int width = 8,
  parameter int nreq  = 4,
  parameter int idw   = idx_width(nreq)
);
  logic [nreq-1:0]       ReqValid;
  logic [nreq-1:0]       ReqReady;
  logic [nreq*width-1:0] ReqA;
  logic                  RspValid;
  logic                  RspReady;
  logic [width-1:0]      RspZ;
  logic                  RspCarry;
  logic [idw-1:0]        RspId;

  modport slave (
    input  ReqValid, ReqA, RspReady,
    output ReqReady, RspValid, RspZ, RspCarry, RspId
  );

  modport master (
    output ReqValid, ReqA, RspReady,
    input  ReqReady, RspValid, RspZ, RspCarry, RspId
  );
endinterface

// File: rtl/inc_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching cyclically from i_ptr.
module rr_pick
  import lau_pkg::*;
#(
  parameter int nreq = 4,
  parameter int idw  = idx_width(nreq)
) (
  input  logic [nreq-1:0] i_req,
  input  logic [idw-1:0]  i_ptr,
  output logic [nreq-1:0] o_grant,
  output logic [idw-1:0]  o_idx,
  output logic            o_any
);
  // Walk the search order backwards so the candidate nearest the pointer is written last and wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = nreq - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % nreq]) begin
        o_grant = '0;
        o_grant[(int'(i_ptr) + k) % nreq] = 1'b1;
        o_idx   = idw'((int'(i_ptr) + k) % nreq);
        o_any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lau_inc.sv
// Combinational incrementer Z = A + 1 built from a prefix-AND of the operand bits.
// SLOW ripples the prefix; MEDIUM/FAST use a log-depth parallel prefix.
module Inc
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] A,
  output logic [width-1:0] Z
);
  // w_pre[i] = &A[i:0]; bit i toggles when every lower bit is one.
  logic [width-1:0] w_pre;

  if (speed == SLOW) begin : g_ripple
    always_comb begin
      w_pre = A;
      for (int i = 1; i < width; i++) begin
        w_pre[i] = w_pre[i-1] & A[i];
      end
    end
  end else begin : g_prefix
    logic [width-1:0] w_lvl;
    always_comb begin
      w_pre = A;
      w_lvl = A;
      for (int s = 1; s < width; s = s * 2) begin
        w_lvl = w_pre;
        for (int i = s; i < width; i++) begin
          w_lvl[i] = w_pre[i] & w_pre[i-s];
        end
        w_pre = w_lvl;
      end
    end
  end

  assign Z = A ^ {w_pre[width-2:0], 1'b1};
endmodule

// File: rtl/inc_share_arbiter.sv
// One incrementer shared by nreq requesters through a round-robin grant and a
// single registered, id-tagged response slot that sustains one result per cycle.
module inc_share_arbiter
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter int     nreq  = 4,
  parameter speed_e speed = FAST
) (
  input logic                 CLK,
  input logic                 RST,
  inc_share_arbiter_if.slave  bus
);
  localparam int idw = idx_width(nreq);

  logic [idw-1:0]   r_ptr;
  logic             r_rsp_valid;
  logic [width-1:0] r_rsp_z;
  logic             r_rsp_carry;
  logic [idw-1:0]   r_rsp_id;

  logic             w_free;
  logic             w_any;
  logic             w_fire;
  logic [nreq-1:0]  w_grant_oh;
  logic [idw-1:0]   w_grant_idx;
  logic [idw-1:0]   w_ptr_nxt;
  logic [width-1:0] w_opnd;
  logic [width-1:0] w_sum;
  logic             w_carry;

  rr_pick #(.nreq(nreq), .idw(idw)) u_pick (
    .i_req   (bus.ReqValid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  // The slot can take a new result when empty or when its current result leaves this cycle.
  assign w_free       = !r_rsp_valid || bus.RspReady;
  assign w_fire       = w_free && w_any;
  assign bus.ReqReady = w_free ? w_grant_oh : '0;

  assign w_opnd  = bus.ReqA[int'(w_grant_idx)*width +: width];
  assign w_carry = &w_opnd;
  assign w_ptr_nxt = (w_grant_idx == idw'(nreq - 1)) ? '0 : w_grant_idx + 1'b1;

  Inc #(.width(width), .speed(speed)) u_inc (
    .A (w_opnd),
    .Z (w_sum)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_z     <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_id    <= '0;
    end else if (w_fire) begin
      r_ptr       <= w_ptr_nxt;
      r_rsp_valid <= 1'b1;
      r_rsp_z     <= w_sum;
      r_rsp_carry <= w_carry;
      r_rsp_id    <= w_grant_idx;
    end else if (bus.RspReady) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.RspValid = r_rsp_valid;
  assign bus.RspZ     = r_rsp_z;
  assign bus.RspCarry = r_rsp_carry;
  assign bus.RspId    = r_rsp_id;
endmodule

// File: tb/tb_inc_share_arbiter.sv
// Directed and randomised checks of the shared incrementer arbiter (width=8, nreq=4).
module tb_inc_share_arbiter;
  import lau_pkg::*;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int IDW  = idx_width(N);
  localparam int SB_W = 1 + IDW + W;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inc_share_arbiter_if #(.width(W), .nreq(N)) bus ();

  inc_share_arbiter #(.width(W), .nreq(N), .speed(FAST)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [SB_W-1:0] exp_q[$];

  logic [W-1:0]    ops [N];
  logic [N-1:0]    r_v;
  logic [N-1:0]    exp_ready;
  logic [SB_W-1:0] e;
  logic            m_valid;
  int              m_ptr;
  int              g;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_a(input int i, input logic [W-1:0] v);
    ops[i] = v;
    bus.ReqA[i*W +: W] = v;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input logic [W-1:0] z, input logic c, input int id);
    check({tag, "_valid"}, 32'(bus.RspValid), 32'd1);
    check({tag, "_z"},     32'(bus.RspZ),     32'(z));
    check({tag, "_carry"}, 32'(bus.RspCarry), 32'(c));
    check({tag, "_id"},    32'(bus.RspId),    32'(id));
  endtask

  function automatic int rr_model(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial begin
    rst          = 1'b1;
    bus.ReqValid = '0;
    bus.ReqA     = '0;
    bus.RspReady = 1'b0;
    for (int i = 0; i < N; i++) ops[i] = '0;
    tick();
    tick();
    check("rst_valid", 32'(bus.RspValid), 32'd0);
    check("rst_z",     32'(bus.RspZ),     32'd0);
    check("rst_carry", 32'(bus.RspCarry), 32'd0);
    check("rst_id",    32'(bus.RspId),    32'd0);
    check("rst_ready", 32'(bus.ReqReady), 32'd0);
    rst = 1'b0;

    // basic single request
    bus.RspReady = 1'b1;
    bus.ReqValid = 4'b0100;
    set_a(2, 8'h3F);
    #1 check("basic_ready", 32'(bus.ReqReady), 32'b0100);
    tick();
    check_rsp("basic", 8'h40, 1'b0, 2);

    // wrap-around and zero operand
    bus.ReqValid = 4'b0001;
    set_a(0, 8'hFF);
    #1 check("wrap_ready", 32'(bus.ReqReady), 32'b0001);
    tick();
    check_rsp("wrap_ff", 8'h00, 1'b1, 0);
    bus.ReqValid = 4'b0010;
    set_a(1, 8'h00);
    tick();
    check_rsp("wrap_00", 8'h01, 1'b0, 1);

    // consumed with nothing pending empties the slot
    bus.ReqValid = '0;
    #1 check("idle_ready", 32'(bus.ReqReady), 32'd0);
    tick();
    check("idle_valid", 32'(bus.RspValid), 32'd0);

    // backpressure: pointer is 2 here
    bus.ReqValid = 4'b0010;
    set_a(1, 8'h10);
    tick();
    check_rsp("bp_load", 8'h11, 1'b0, 1);
    bus.RspReady = 1'b0;
    bus.ReqValid = 4'b1000;
    set_a(3, 8'h7F);
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_ready", 32'(bus.ReqReady), 32'd0);
      tick();
      check_rsp("bp_hold", 8'h11, 1'b0, 1);
    end
    bus.RspReady = 1'b1;
    #1 check("bp_pop_ready", 32'(bus.ReqReady), 32'b1000);
    tick();
    check_rsp("bp_next", 8'h80, 1'b0, 3);

    // leave pointer at 1 with a response held, then reset mid-stream
    bus.ReqValid = 4'b0001;
    set_a(0, 8'h05);
    tick();
    check_rsp("pre_rst", 8'h06, 1'b0, 0);
    bus.ReqValid = '0;
    bus.RspReady = 1'b0;
    tick();
    check("pre_rst_hold", 32'(bus.RspValid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.RspValid), 32'd0);
    check("mid_rst_z",     32'(bus.RspZ),     32'd0);
    check("mid_rst_id",    32'(bus.RspId),    32'd0);
    #1 rst = 1'b0;

    // round robin with all requesters active
    for (int i = 0; i < N; i++) set_a(i, 8'((i + 1) * 16));
    bus.ReqValid = 4'b1111;
    bus.RspReady = 1'b1;
    #1 check("rr_first_ready", 32'(bus.ReqReady), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_rsp($sformatf("rr%0d", k), 8'(((k % N) + 1) * 16 + 1), 1'b0, k % N);
    end

    // sparse requesters 1 and 3 with pointer at 2
    bus.ReqValid = 4'b1010;
    #1 check("sp_ready0", 32'(bus.ReqReady), 32'b1000);
    tick();
    check_rsp("sp0", 8'h41, 1'b0, 3);
    #1 check("sp_ready1", 32'(bus.ReqReady), 32'b0010);
    tick();
    check_rsp("sp1", 8'h21, 1'b0, 1);
    tick();
    check_rsp("sp2", 8'h41, 1'b0, 3);

    bus.ReqValid = '0;
    tick();
    check("drain_valid", 32'(bus.RspValid), 32'd0);

    // random operands and backpressure against a behavioural model; pointer is 0 here
    m_valid = 1'b0;
    m_ptr   = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      r_v = N'($urandom_range(0, (1 << N) - 1));
      bus.RspReady = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) set_a(i, 8'hFF);
        else                           set_a(i, 8'($urandom_range(0, 255)));
      end
      bus.ReqValid = r_v;
      #1;
      check("rnd_valid", 32'(bus.RspValid), 32'(m_valid));
      if (bus.RspValid && bus.RspReady) begin
        check("rnd_q_nonempty", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rnd_rsp", 32'({bus.RspCarry, bus.RspId, bus.RspZ}), 32'(e));
        end
      end
      g = rr_model(r_v, m_ptr);
      if ((!m_valid || bus.RspReady) && g >= 0) begin
        exp_ready = N'(1 << g);
        exp_q.push_back({(ops[g] == 8'hFF), IDW'(g), 8'(ops[g] + 8'd1)});
        m_ptr   = (g + 1) % N;
        m_valid = 1'b1;
      end else begin
        exp_ready = '0;
        if (bus.RspReady) m_valid = 1'b0;
      end
      check("rnd_ready", 32'(bus.ReqReady), 32'(exp_ready));
      tick();
    end

    bus.ReqValid = '0;
    bus.RspReady = 1'b1;
    #1;
    if (bus.RspValid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("end_rsp", 32'({bus.RspCarry, bus.RspId, bus.RspZ}), 32'(e));
    end
    tick();
    check("end_valid", 32'(bus.RspValid), 32'd0);
    check("end_q", 32'(exp_q.size()), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inc_share_arbiter.md
Name: inc_share_arbiter

Overview:
- Shares one combinational prefix-propagate incrementer (Inc, Z = A+1) between nreq independent requesters.
- Round-robin arbitration over valid/ready request channels; one registered response channel tagged with the requester index.
- Used where several counters or address generators in a datapath need an occasional increment and a dedicated incrementer per requester is too costly.

Parameters:
- width, 8, operand/result word width (>= 2)
- nreq, 4, number of requesters (>= 1)
- speed, lau_pkg::FAST, performance parameter passed to the shared Inc instance
- idw, max(1,$clog2(nreq)), derived localparam; width of the response id

Ports:
- CLK  input  1  clock, all state on rising edge
- RST  input  1  asynchronous reset, active-high
- ReqValid  input  nreq  per-requester operand valid
- ReqReady  output  nreq  per-requester accept; one-hot or zero
- ReqA  input  nreq*width  packed operands; requester i at bits [i*width +: width]
- RspValid  output  1  response register holds valid result
- RspReady  input  1  consumer accepts response
- RspZ  output  width  registered A+1 modulo 2^width
- RspCarry  output  1  registered carry-out; 1 iff granted A was all ones
- RspId  output  idw  index of the requester whose result is in RspZ

Behaviour:
- Reset (RST=1, asynchronous): RspValid=0, RspZ=0, RspCarry=0, RspId=0, round-robin pointer=0. ReqReady is combinational and is 0 while RspValid=0 and no ReqValid is set.
- Slot free: free = !RspValid || RspReady.
- Grant: when free, grant = first i with ReqValid[i]=1, searching cyclically from pointer ptr (ptr, ptr+1, ..., nreq-1, 0, ..., ptr-1).
  - ReqReady[grant]=1; all other ReqReady bits 0.
  - When not free or no ReqValid is set, ReqReady=0.
- ReqReady depends combinationally on ReqValid and RspReady. ReqValid must not depend on ReqReady.
- Transfer: a request handshake (ReqValid[i] && ReqReady[i]) at edge k loads the response register:
  - RspZ = ReqA[i]+1, RspCarry = &ReqA[i], RspId = i, RspValid = 1, visible after edge k.
  - Latency is 1 cycle, request handshake to RspValid.
- Pointer update: on a request handshake, ptr <= (grant+1) mod nreq. Otherwise ptr holds.
- Response hold: RspValid && !RspReady holds RspZ/RspCarry/RspId stable and accepts no request.
- Simultaneous events: response consumed and new request accepted in the same cycle, giving full throughput of 1 result per cycle. Response consumed with no request pending clears RspValid to 0.
- Fairness: any continuously asserted ReqValid is granted within nreq accepted transfers.
- Arithmetic: wrap-around, all-ones + 1 = 0 with RspCarry=1. No saturation.
- nreq=1: arbitration degenerates to ReqReady[0] = free; ptr is constant 0; RspId=0.
- Reset mid-operation: any pending response is discarded (RspValid=0) and the pointer returns to 0. No request is considered accepted during reset.
- Datapath: exactly one Inc #(.width(width), .speed(speed)) instance, fed by the granted operand mux. Carry is computed as the AND-reduce of the same muxed operand.

Decomposition:
- lau_pkg: add function idx_width(n) returning max(1,$clog2(n)), used for idw. The existing speed_e is reused.
- One sub-module: rr_pick #(nreq): combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any flag.
- The top level holds the pointer, the response register, the operand mux and the Inc instance.

Test Plan:
- Reset: assert RST mid-stream with RspValid=1 -> RspValid=0, RspZ=0, RspId=0 immediately. After release, requesters 0..3 all valid -> requester 0 granted first.
- Basic, width=8: single request i=2, A=0x3F, RspReady=1 -> ReqReady=0b0100 that cycle. Next cycle RspValid=1, RspZ=0x40, RspCarry=0, RspId=2.
- Wrap: A=0xFF -> RspZ=0x00, RspCarry=1. A=0x00 -> RspZ=0x01, RspCarry=0.
- Round-robin: all four ReqValid held high, RspReady=1 -> RspId sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
- Backpressure: RspReady=0 for 3 cycles with response (Z=0x11, id=1) pending -> outputs stable, ReqReady=0. RspReady=1 -> next request accepted in the same cycle as the pop.
- Sparse/fairness: requesters 1 and 3 valid, ptr=2 -> grant 3, then 1, then 3. Compare all results against a behavioural A+1 model with random operands and random RspReady.
